maze_mem_arbiter: RTL and testbench
===================================

Name: maze_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 16x16 maze_memory between requester A (intelligent_rat solver) and requester B (maze loader/viewer).
- Round-robin ownership with bounded bursts. Owner streams one access per cycle with no wait state.
- Read data is returned registered, one cycle after the access.
- Sits between both requesters and the memory's X/Y/D_in/RD/WR/D_out port.

Parameters:
- MAX_BURST, 4, max consecutive granted accesses by the owner while the other requester waits (1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- a_req  input  1  requester A wants an access this cycle
- a_wr  input  1  1 = write, 0 = read
- a_x  input  4  column address
- a_y  input  4  row address
- a_din  input  1  write data
- a_gnt  output  1  access by A executes this cycle
- a_rvalid  output  1  a_rdata valid (one cycle after A read)
- a_rdata  output  1  registered read data
- b_req, b_wr, b_x, b_y, b_din, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- mem_x  output  4  to memory X
- mem_y  output  4  to memory Y
- mem_din  output  1  to memory D_in
- mem_rd  output  1  to memory RD
- mem_wr  output  1  to memory WR
- mem_dout  input  1  from memory D_out; combinational read assumed valid in the RD cycle

Behaviour:
- Owner state register: IDLE, OWN_A, OWN_B.
- Priority pointer last_b (1 = B was last owner). Burst counter burst[3:0].
- Grant is combinational:
  - a_gnt = (owner==OWN_A) & a_req
  - b_gnt = (owner==OWN_B) & b_req
  - Never both high.
- Access cycle (x_gnt=1):
  - mem_x/mem_y/mem_din are driven from the owner's inputs.
  - mem_wr = x_wr and mem_rd = ~x_wr; the two are mutually exclusive.
- No access: mem_rd = mem_wr = 0 and mem_x = mem_y = mem_din = 0.
- Read return: on a granted read, mem_dout is registered into x_rdata, and x_rvalid=1 for exactly the next cycle.
  - Writes produce no rvalid.
  - x_rdata holds its last value otherwise.
- Requester handshake:
  - Holds req/addr/data until it sees gnt.
  - May present a new address the cycle after gnt (pipelined streaming).
- Next-owner logic, evaluated on the current cycle's reqs:
  - IDLE:
    - Neither req: stay IDLE.
    - One req: owner = that requester.
    - Both reqs: owner = A if last_b=1, else B.
    - burst <= 0.
  - OWN_X with x_req & (burst+1 < MAX_BURST | ~other_req): stay; burst <= burst+1, saturating at 15.
  - OWN_X otherwise, other_req=1: owner = other; burst <= 0; last_b updated to the new owner.
  - OWN_X otherwise, other_req=0: owner = IDLE; burst <= 0.
- Latency:
  - First request from IDLE, or a waiting requester: grant in the cycle after req is first seen.
  - Owner streaming: zero wait.
- Starvation bound: a waiting requester is granted within MAX_BURST+1 cycles.
- Owner drops req mid-burst: ownership passes (or goes IDLE) at the next edge; no access occurs in the drop cycle.
- Reset (also mid-burst): owner=IDLE, last_b=1 (A wins the first tie), burst=0, all gnt/rvalid/rdata=0, mem_* = 0.
  - Any pending rvalid is cancelled.

Optional Feature:
- MAZE_ARB_STATS_EN defined: adds three outputs:
  - a_count[15:0]: granted A accesses
  - b_count[15:0]: granted B accesses
  - wait_count[15:0]: cycles where a req was high and not granted
- Counters are saturating, cleared by rst.
- MAZE_ARB_STATS_EN undefined: the ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single read:
  - Stimulus: after reset, A reads (x=3, y=5) with memory bit = 1.
  - Required: a_gnt in cycle 1 after req; mem_rd=1 with mem_x=3, mem_y=5 in that cycle; a_rvalid=1, a_rdata=1 the next cycle.
- Tie after reset:
  - Stimulus: a_req and b_req rise together.
  - Required: A granted first.
  - Stimulus: A drops after one access.
  - Required: B granted the next cycle; a subsequent tie from IDLE grants A (last_b=1).
- Burst limit:
  - Stimulus: MAX_BURST=4; B streams continuously; A requests in burst cycle 2.
  - Required: B gets exactly 4 consecutive grants, then A is granted; B is regranted after A's burst or drop.
- Write/read-back:
  - Stimulus: B writes din=1 at (15,15), then A reads (15,15).
  - Required: mem_wr pulse one cycle; A's rdata=1; no b_rvalid for the write.
- Reset mid-burst:
  - Stimulus: rst=1 during an A read burst.
  - Required: next cycle all gnt/rvalid=0, mem_rd=mem_wr=0, owner IDLE; normal grant after rst falls.
- Stats (MAZE_ARB_STATS_EN):
  - Stimulus: 10 A accesses, 3 B accesses, 3 contended wait cycles.
  - Required: a_count=10, b_count=3, wait_count=3; all counters 0 after rst.

Source files
------------

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port 16x16 maze memory between the rat solver (A)
// and the loader/viewer (B). Optional statistics counters are built when MAZE_ARB_STATS_EN is defined.
module maze_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_wr,
  input  logic [3:0] a_x,
  input  logic [3:0] a_y,
  input  logic       a_din,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic       a_rdata,
  input  logic       b_req,
  input  logic       b_wr,
  input  logic [3:0] b_x,
  input  logic [3:0] b_y,
  input  logic       b_din,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic       b_rdata,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       mem_din,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_dout
`ifdef MAZE_ARB_STATS_EN
  ,
  output logic [15:0] a_count,
  output logic [15:0] b_count,
  output logic [15:0] wait_count
`endif
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;

  owner_t          owner, owner_nx;
  logic            last_b, last_b_nx;
  logic [3:0]      burst, burst_nx;
  logic            burst_room;
  logic [3:0]      burst_inc;

  // Requester 0 is A, requester 1 is B.
  logic [1:0]      req, wr, din, gnt, rvalid, rdata;
  logic [1:0][3:0] x, y;
  logic            sel;

  assign req = {b_req, a_req};
  assign wr  = {b_wr, a_wr};
  assign din = {b_din, a_din};
  assign x   = {b_x, a_x};
  assign y   = {b_y, a_y};

  assign burst_room = ({1'b0, burst} + 5'd1) < 5'(MAX_BURST);
  assign burst_inc  = (burst == 4'hF) ? burst : burst + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= IDLE;
      last_b <= 1'b1;
      burst  <= '0;
    end else begin
      owner  <= owner_nx;
      last_b <= last_b_nx;
      burst  <= burst_nx;
    end
  end

  always_comb begin
    owner_nx  = owner;
    last_b_nx = last_b;
    burst_nx  = burst;
    case (owner)
      IDLE: begin
        burst_nx = '0;
        if (a_req && b_req) owner_nx = last_b ? OWN_A : OWN_B;
        else if (a_req)     owner_nx = OWN_A;
        else if (b_req)     owner_nx = OWN_B;
      end
      OWN_A: begin
        if (a_req && (burst_room || !b_req)) begin
          burst_nx = burst_inc;
        end else begin
          burst_nx = '0;
          if (b_req) begin
            owner_nx  = OWN_B;
            last_b_nx = 1'b1;
          end else begin
            owner_nx = IDLE;
          end
        end
      end
      OWN_B: begin
        if (b_req && (burst_room || !a_req)) begin
          burst_nx = burst_inc;
        end else begin
          burst_nx = '0;
          if (a_req) begin
            owner_nx  = OWN_A;
            last_b_nx = 1'b0;
          end else begin
            owner_nx = IDLE;
          end
        end
      end
      default: owner_nx = IDLE;
    endcase
  end

  assign gnt[0] = (owner == OWN_A) && a_req;
  assign gnt[1] = (owner == OWN_B) && b_req;
  assign a_gnt  = gnt[0];
  assign b_gnt  = gnt[1];
  assign sel    = gnt[1];

  // Memory port is forced to zero whenever nobody is granted.
  always_comb begin
    mem_x   = '0;
    mem_y   = '0;
    mem_din = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    if (|gnt) begin
      mem_x   = x[sel];
      mem_y   = y[sel];
      mem_din = din[sel];
      mem_wr  = wr[sel];
      mem_rd  = ~wr[sel];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rd
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid[i] <= 1'b0;
        rdata[i]  <= 1'b0;
      end else begin
        rvalid[i] <= gnt[i] & ~wr[i];
        if (gnt[i] && !wr[i]) rdata[i] <= mem_dout;
      end
    end
  end

  assign a_rvalid = rvalid[0];
  assign a_rdata  = rdata[0];
  assign b_rvalid = rvalid[1];
  assign b_rdata  = rdata[1];

`ifdef MAZE_ARB_STATS_EN
  logic waiting;
  assign waiting = |(req & ~gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count    <= '0;
      b_count    <= '0;
      wait_count <= '0;
    end else begin
      if (gnt[0] && a_count != 16'hFFFF)    a_count    <= a_count + 16'd1;
      if (gnt[1] && b_count != 16'hFFFF)    b_count    <= b_count + 16'd1;
      if (waiting && wait_count != 16'hFFFF) wait_count <= wait_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: per-scenario tasks plus a read-data scoreboard
// fed from a behavioural 16x16 memory.
module tb_maze_mem_arbiter;
  logic       clk, rst;
  logic       a_req, a_wr, a_din, b_req, b_wr, b_din;
  logic [3:0] a_x, a_y, b_x, b_y;
  logic       a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata;
  logic [3:0] mem_x, mem_y;
  logic       mem_din, mem_rd, mem_wr, mem_dout;
`ifdef MAZE_ARB_STATS_EN
  logic [15:0] a_count, b_count, wait_count;
`endif

  int total = 0;
  int bad = 0;

  bit         mem_arr [0:15][0:15];
  logic       poke_en, poke_v;
  logic [3:0] poke_x, poke_y;
  bit         qa [$];
  bit         qb [$];

  maze_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_x(a_x), .a_y(a_y), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_x(b_x), .b_y(b_y), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_x(mem_x), .mem_y(mem_y), .mem_din(mem_din), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_dout(mem_dout)
`ifdef MAZE_ARB_STATS_EN
    , .a_count(a_count), .b_count(b_count), .wait_count(wait_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the clock edge.
  assign mem_dout = mem_rd ? mem_arr[mem_y][mem_x] : 1'b0;
  always @(posedge clk) begin
    if (poke_en)     mem_arr[poke_y][poke_x] <= poke_v;
    else if (mem_wr) mem_arr[mem_y][mem_x] <= mem_din;
  end

  // Scoreboard: expected read data is queued at the grant, checked on the following cycle.
  always @(negedge clk) begin
    bit ev, d;
    ev = (qa.size() > 0);
    total++;
    if (a_rvalid !== ev) begin bad++; $display("FAIL sb_a_rvalid got=%b exp=%b t=%0t", a_rvalid, ev, $time); end
    if (ev) begin
      d = qa.pop_front();
      total++;
      if (a_rdata !== d) begin bad++; $display("FAIL sb_a_rdata got=%b exp=%b t=%0t", a_rdata, d, $time); end
    end
    ev = (qb.size() > 0);
    total++;
    if (b_rvalid !== ev) begin bad++; $display("FAIL sb_b_rvalid got=%b exp=%b t=%0t", b_rvalid, ev, $time); end
    if (ev) begin
      d = qb.pop_front();
      total++;
      if (b_rdata !== d) begin bad++; $display("FAIL sb_b_rdata got=%b exp=%b t=%0t", b_rdata, d, $time); end
    end
    total++;
    if ((a_gnt & b_gnt) !== 1'b0 || (mem_rd & mem_wr) !== 1'b0) begin
      bad++; $display("FAIL sb_exclusive gnt=%b%b rd=%b wr=%b t=%0t", a_gnt, b_gnt, mem_rd, mem_wr, $time);
    end
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_gnt === 1'b1 && a_wr === 1'b0) qa.push_back(mem_arr[a_y][a_x]);
      if (b_gnt === 1'b1 && b_wr === 1'b0) qb.push_back(mem_arr[b_y][b_x]);
    end
  end

  task step;
    @(posedge clk); #1;
  endtask

  task poke(input logic [3:0] px, input logic [3:0] py, input logic v);
    poke_x = px; poke_y = py; poke_v = v; poke_en = 1'b1;
    step();
    poke_en = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b exp=000000", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata});
    end
    total++;
    if ({mem_x, mem_y, mem_din, mem_rd, mem_wr} !== 11'b0) begin
      bad++; $display("FAIL reset_mem got=%h exp=0", {mem_x, mem_y, mem_din, mem_rd, mem_wr});
    end
    step();
    rst = 1'b0;
  endtask

  task test_single_read;
    poke(4'd3, 4'd5, 1'b1);
    a_req = 1'b1; a_wr = 1'b0; a_x = 4'd3; a_y = 4'd5;
    @(negedge clk);
    total++;
    if (a_gnt !== 1'b0) begin bad++; $display("FAIL single_nognt_c0 got=%b exp=0", a_gnt); end
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, mem_rd, mem_wr} !== 3'b110) begin bad++; $display("FAIL single_gnt got=%b exp=110", {a_gnt, mem_rd, mem_wr}); end
    total++;
    if (mem_x !== 4'd3 || mem_y !== 4'd5) begin bad++; $display("FAIL single_addr got=%0d,%0d exp=3,5", mem_x, mem_y); end
    step();
    a_req = 1'b0;
    @(negedge clk);
    total++;
    if ({a_rvalid, a_rdata, a_gnt} !== 3'b110) begin bad++; $display("FAIL single_rdata got=%b exp=110", {a_rvalid, a_rdata, a_gnt}); end
    step();
    step();
  endtask

  task test_tie;
    a_req = 1'b1; b_req = 1'b1; a_wr = 1'b0; b_wr = 1'b0;
    a_x = 4'd1; a_y = 4'd1; b_x = 4'd2; b_y = 4'd2;
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt} !== 2'b00) begin bad++; $display("FAIL tie_idle got=%b exp=00", {a_gnt, b_gnt}); end
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL tie_first_a got=%b exp=10", {a_gnt, b_gnt}); end
    step();
    a_req = 1'b0;
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt} !== 2'b00) begin bad++; $display("FAIL tie_drop_cycle got=%b exp=00", {a_gnt, b_gnt}); end
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt} !== 2'b01) begin bad++; $display("FAIL tie_then_b got=%b exp=01", {a_gnt, b_gnt}); end
    step();
    b_req = 1'b0;
    step();
    a_req = 1'b1; b_req = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL tie_again_a got=%b exp=10", {a_gnt, b_gnt}); end
    step();
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();
  endtask

  task test_burst;
    int exp_g [11];
    exp_g = '{0, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2};
    poke(4'd3, 4'd0, 1'b1);
    poke(4'd6, 4'd1, 1'b1);
    for (int k = 0; k < 11; k++) begin
      b_req = 1'b1; b_wr = 1'b0; b_x = 4'(k); b_y = 4'd0;
      a_req = (k >= 2 && k < 9); a_wr = 1'b0; a_x = 4'(k); a_y = 4'd1;
      @(negedge clk);
      total++;
      if (a_gnt !== (exp_g[k] == 1) || b_gnt !== (exp_g[k] == 2)) begin
        bad++; $display("FAIL burst_c%0d got=%b%b exp_owner=%0d", k, a_gnt, b_gnt, exp_g[k]);
      end
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();
  endtask

  task test_write_read;
    b_req = 1'b1; b_wr = 1'b1; b_x = 4'd15; b_y = 4'd15; b_din = 1'b1;
    @(negedge clk);
    total++;
    if (b_gnt !== 1'b0) begin bad++; $display("FAIL wr_nognt got=%b exp=0", b_gnt); end
    step();
    @(negedge clk);
    total++;
    if ({b_gnt, mem_wr, mem_rd, mem_din} !== 4'b1101) begin bad++; $display("FAIL wr_pulse got=%b exp=1101", {b_gnt, mem_wr, mem_rd, mem_din}); end
    total++;
    if (mem_x !== 4'd15 || mem_y !== 4'd15) begin bad++; $display("FAIL wr_addr got=%0d,%0d exp=15,15", mem_x, mem_y); end
    step();
    b_req = 1'b0; b_wr = 1'b0; b_din = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_x = 4'd15; a_y = 4'd15;
    @(negedge clk);
    total++;
    if ({mem_wr, b_rvalid, a_gnt} !== 3'b000) begin bad++; $display("FAIL wr_after got=%b exp=000", {mem_wr, b_rvalid, a_gnt}); end
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, mem_rd} !== 2'b11) begin bad++; $display("FAIL rb_gnt got=%b exp=11", {a_gnt, mem_rd}); end
    step();
    a_req = 1'b0;
    @(negedge clk);
    total++;
    if ({a_rvalid, a_rdata, b_rvalid} !== 3'b110) begin bad++; $display("FAIL rb_data got=%b exp=110", {a_rvalid, a_rdata, b_rvalid}); end
    step();
    step();
  endtask

  task test_reset_mid;
    a_req = 1'b1; a_wr = 1'b0; a_x = 4'd3; a_y = 4'd5;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    b_req = 1'b1; b_wr = 1'b0; b_x = 4'd0; b_y = 4'd0;
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin bad++; $display("FAIL rstmid_gnt got=%b exp=0000", {a_gnt, b_gnt, a_rvalid, b_rvalid}); end
    total++;
    if ({mem_rd, mem_wr, a_rdata} !== 3'b000) begin bad++; $display("FAIL rstmid_mem got=%b exp=000", {mem_rd, mem_wr, a_rdata}); end
    step();
    @(negedge clk);
    total++;
    if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL rstmid_regrant got=%b exp=10", {a_gnt, b_gnt}); end
    step();
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();
  endtask

`ifdef MAZE_ARB_STATS_EN
  task test_stats;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_count, b_count, wait_count} !== 48'b0) begin bad++; $display("FAIL stats_clear got=%0d,%0d,%0d exp=0,0,0", a_count, b_count, wait_count); end
    for (int k = 0; k < 16; k++) begin
      a_req = (k <= 10) || (k == 14); a_wr = 1'b0; a_x = 4'd0; a_y = 4'd2;
      b_req = (k >= 11 && k <= 14); b_wr = 1'b0; b_x = 4'd1; b_y = 4'd2;
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    total++;
    if (a_count !== 16'd10 || b_count !== 16'd3 || wait_count !== 16'd3) begin
      bad++; $display("FAIL stats_counts got=%0d,%0d,%0d exp=10,3,3", a_count, b_count, wait_count);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_count, b_count, wait_count} !== 48'b0) begin bad++; $display("FAIL stats_rst got=%0d,%0d,%0d exp=0,0,0", a_count, b_count, wait_count); end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_wr = 1'b0; a_x = '0; a_y = '0; a_din = 1'b0;
    b_req = 1'b0; b_wr = 1'b0; b_x = '0; b_y = '0; b_din = 1'b0;
    poke_en = 1'b0; poke_v = 1'b0; poke_x = '0; poke_y = '0;
    step();
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_write_read();
    test_reset_mid();
`ifdef MAZE_ARB_STATS_EN
    test_stats();
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
